// File: rtl/demux_4ch_dispatcher.sv
// 1-to-4 word dispatcher: holds one accepted word and offers it on a single channel
// (addressed or round-robin); a stalled consumer causes the word to be dropped after TIMEOUT cycles.
module demux_4ch_lane #(
  parameter int DATA_WIDTH = 2,
  parameter int IDX        = 0
) (
  input  logic                  hold,
  input  logic [1:0]            sel,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] dout
);
  assign valid = hold && (sel == 2'(IDX));
  assign dout  = valid ? data : '0;
endmodule

module demux_4ch_dispatcher #(
  parameter int DATA_WIDTH = 2,
  parameter int TIMEOUT    = 15,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_dest,
  input  logic                  mode,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [DATA_WIDTH-1:0] out_data0,
  output logic [DATA_WIDTH-1:0] out_data1,
  output logic [DATA_WIDTH-1:0] out_data2,
  output logic [DATA_WIDTH-1:0] out_data3,
  output logic                  busy,
  output logic [1:0]            cur_sel,
  output logic                  drop,
  output logic [CNT_WIDTH-1:0]  tx_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);
  typedef enum logic {IDLE, HOLD} state_t;

  localparam int            WW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam bit            TO_EN = (TIMEOUT != 0);
  localparam logic [WW-1:0] WLAST = TO_EN ? WW'(TIMEOUT - 1) : '0;

  state_t                          state;
  logic [1:0]                      sel;
  logic [1:0]                      rr_ptr;
  logic                            rr_word;
  logic [DATA_WIDTH-1:0]           data_q;
  logic [WW-1:0]                   wait_cnt;
  logic                            hold;
  logic [3:0][DATA_WIDTH-1:0]      ch_data;

  assign hold     = (state == HOLD);
  assign in_ready = (state == IDLE);
  assign busy     = hold;
  assign cur_sel  = hold ? sel : 2'b00;

  // One lane per channel; unselected lanes read as zero like a plain demux.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    demux_4ch_lane #(.DATA_WIDTH(DATA_WIDTH), .IDX(g)) u_lane (
      .hold  (hold),
      .sel   (sel),
      .data  (data_q),
      .valid (out_valid[g]),
      .dout  (ch_data[g])
    );
  end

  assign out_data0 = ch_data[0];
  assign out_data1 = ch_data[1];
  assign out_data2 = ch_data[2];
  assign out_data3 = ch_data[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      rr_ptr     <= '0;
      rr_word    <= 1'b0;
      data_q     <= '0;
      wait_cnt   <= '0;
      drop       <= 1'b0;
      tx_count   <= '0;
      drop_count <= '0;
    end else begin
      drop <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          data_q   <= in_data;
          sel      <= mode ? rr_ptr : in_dest;
          rr_word  <= mode;
          wait_cnt <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          // Delivery takes priority over a timeout landing on the same edge.
          if (out_ready[sel]) begin
            tx_count <= tx_count + 1'b1;
            if (rr_word) rr_ptr <= rr_ptr + 2'd1;
            state <= IDLE;
          end else if (TO_EN && wait_cnt == WLAST) begin
            drop <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
            if (rr_word) rr_ptr <= rr_ptr + 2'd1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
